cluster_decoder768: RTL

CLUSTER_DECODER768 -- requirements
Module: cluster_decoder768

---
 rtl/cluster_decoder768_pkg.sv | 26 ++
 rtl/cluster_decoder768_expand.sv | 29 ++
 rtl/cluster_decoder768.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cluster_decoder768_pkg.sv
// ----------------------------------------------------------------------------
// cluster_decoder768_pkg
// Shared constants for the cluster decoder: frame geometry, cluster word
// field widths, the "no cluster" address, error flag bit positions and the
// two controller states.
// ----------------------------------------------------------------------------
package cluster_decoder768_pkg;

    localparam int MXPADS     = 768;
    localparam int MXCLUSTERS = 8;

    localparam int ADR_W = 11;
    localparam int CNT_W = 3;

    // Encoder emits this key pad when it has no cluster to report.
    localparam logic [ADR_W-1:0] NULL_ADR = 11'h7FF;

    // Bit positions inside err = {overflow, bad_adr, pass_err}.
    localparam int ERR_PASS     = 0;
    localparam int ERR_BAD_ADR  = 1;
    localparam int ERR_OVERFLOW = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

endpackage

// File: rtl/cluster_decoder768_expand.sv
// ----------------------------------------------------------------------------
// cluster_expand
// Expands one cluster word into a hit mask: bits adr .. adr+cnt are set,
// clipped at the last pad. An address beyond the frame yields an empty mask.
//   adr  : key pad of the cluster
//   cnt  : cluster size minus one
//   hits : MXPADS-wide hit mask
// ----------------------------------------------------------------------------
module cluster_expand #(
    parameter int MXPADS = cluster_decoder768_pkg::MXPADS
) (
    input  logic [cluster_decoder768_pkg::ADR_W-1:0] adr,
    input  logic [cluster_decoder768_pkg::CNT_W-1:0] cnt,
    output logic [MXPADS-1:0]                        hits
);

    // One bit wider than adr so adr+cnt cannot wrap.
    logic [11:0] first_pad;
    logic [11:0] last_pad;

    assign first_pad = {1'b0, adr};
    assign last_pad  = first_pad + {9'b0, cnt};

    // Clipping falls out naturally: pads past MXPADS-1 simply do not exist.
    for (genvar g = 0; g < MXPADS; g++) begin : g_pad
        assign hits[g] = (first_pad <= 12'(g)) && (12'(g) <= last_pad);
    end

endmodule

// File: rtl/cluster_decoder768.sv
// ----------------------------------------------------------------------------
// cluster_decoder768
// Rebuilds a per-pad frame from a stream of cluster words. Words accumulate
// between latch_pulse strobes; each latch_pulse (after the first) publishes
// the accumulated frame and starts a fresh one.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   latch_pulse    : frame boundary strobe
//   cluster_found  : cluster word valid; adr / cnt / pass_in are the word
//   vpfs_out       : cluster-start flag per pad
//   cnts_out       : per-pad cnt, 3 bits at [ipad*3+2:ipad*3]
//   hits_out       : expanded hit mask
//   frame_valid    : one-cycle strobe, outputs just updated
//   nclusters      : clusters accepted in the emitted frame
//   err            : {overflow, bad_adr, pass_err} for the emitted frame
// ----------------------------------------------------------------------------
module cluster_decoder768 #(
    parameter int MXPADS     = cluster_decoder768_pkg::MXPADS,
    parameter int MXCLUSTERS = cluster_decoder768_pkg::MXCLUSTERS
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     latch_pulse,
    input  logic                                     cluster_found,
    input  logic [cluster_decoder768_pkg::ADR_W-1:0] adr,
    input  logic [cluster_decoder768_pkg::CNT_W-1:0] cnt,
    input  logic [2:0]                               pass_in,
    output logic [MXPADS-1:0]                        vpfs_out,
    output logic [MXPADS*3-1:0]                      cnts_out,
    output logic [MXPADS-1:0]                        hits_out,
    output logic                                     frame_valid,
    output logic [3:0]                               nclusters,
    output logic [2:0]                               err
);

    import cluster_decoder768_pkg::*;

    localparam int PAD_W = $clog2(MXPADS);
    localparam int CNT_IDX_W = $clog2(MXPADS*3);
    localparam logic [ADR_W-1:0] PADS_LIMIT = ADR_W'(MXPADS);
    localparam logic [3:0] COUNT_LIMIT = 4'(MXCLUSTERS);

    logic [0:0]          state, state_nxt;
    logic [MXPADS-1:0]   vpf_acc, vpf_nxt;
    logic [MXPADS*3-1:0] cnt_acc, cnt_nxt;
    logic [MXPADS-1:0]   hit_acc, hit_nxt;
    logic [3:0]          count, count_nxt;
    logic [2:0]          err_acc, err_nxt;
    logic [2:0]          exp_pass, exp_pass_nxt;

    logic [MXPADS-1:0]   word_hits;
    logic [PAD_W-1:0]    pad;
    logic [CNT_IDX_W-1:0] cnt_base;

    cluster_expand #(.MXPADS(MXPADS)) u_expand (
        .adr  (adr),
        .cnt  (cnt),
        .hits (word_hits)
    );

    // Only meaningful when adr < MXPADS; the index is widened before the
    // multiply so the 3-bit field offset cannot overflow.
    assign pad      = adr[PAD_W-1:0];
    assign cnt_base = CNT_IDX_W'(pad) * CNT_IDX_W'(3);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no
        // path leaves it unassigned and no latch is inferred.
        state_nxt    = state;
        vpf_nxt      = vpf_acc;
        cnt_nxt      = cnt_acc;
        hit_nxt      = hit_acc;
        count_nxt    = count;
        err_nxt      = err_acc;
        exp_pass_nxt = exp_pass;

        if (state == ST_IDLE) begin
            // Accumulator is already clear here; words are ignored.
            if (latch_pulse) state_nxt = ST_ACCUM;
        end else begin
            // Frame boundary clears first so a coincident word lands in the
            // new frame.
            if (latch_pulse) begin
                vpf_nxt      = '0;
                cnt_nxt      = '0;
                hit_nxt      = '0;
                count_nxt    = '0;
                err_nxt      = '0;
                exp_pass_nxt = '0;
            end
            if (cluster_found) begin
                // Pass tracking advances for every word, accepted or not.
                if (pass_in != exp_pass_nxt) err_nxt[ERR_PASS] = 1'b1;
                exp_pass_nxt = exp_pass_nxt + 3'd1;

                if (adr == NULL_ADR || adr >= PADS_LIMIT) begin
                    err_nxt[ERR_BAD_ADR] = 1'b1;
                end else if (count_nxt == COUNT_LIMIT) begin
                    err_nxt[ERR_OVERFLOW] = 1'b1;
                end else begin
                    vpf_nxt[pad]            = 1'b1;
                    cnt_nxt[cnt_base +: 3]  = cnt;
                    hit_nxt                 = hit_nxt | word_hits;
                    count_nxt               = count_nxt + 4'd1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            vpf_acc  <= '0;
            cnt_acc  <= '0;
            hit_acc  <= '0;
            count    <= '0;
            err_acc  <= '0;
            exp_pass <= '0;
        end else begin
            state    <= state_nxt;
            vpf_acc  <= vpf_nxt;
            cnt_acc  <= cnt_nxt;
            hit_acc  <= hit_nxt;
            count    <= count_nxt;
            err_acc  <= err_nxt;
            exp_pass <= exp_pass_nxt;
        end
    end

    // Output registers capture the pre-clear accumulator on a boundary
    // in ACCUM and hold until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpfs_out    <= '0;
            cnts_out    <= '0;
            hits_out    <= '0;
            nclusters   <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= latch_pulse && (state == ST_ACCUM);
            if (latch_pulse && state == ST_ACCUM) begin
                vpfs_out  <= vpf_acc;
                cnts_out  <= cnt_acc;
                hits_out  <= hit_acc;
                nclusters <= count;
                err       <= err_acc;
            end
        end
    end

endmodule
